// File: rtl/row_clear_engine.sv
// row_clear_engine
//   Producer side of the CLEAR_ROW handshake. On entry to CLEAR_STATE the
//   settled board is snapshotted. Every full row is removed and the rows above
//   it are compacted downward. The compacted board and the number of removed
//   rows are then published together with a one-cycle done_clear pulse.
//   Only one pass runs per visit to CLEAR_STATE.
//   Board bit index = row*COLS + col. Row 0 is the top row.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous, active-high reset
//   game_current_state  top-level game FSM state
//   blocks_exist        current board, sampled only at pass start
//   blocks_exist_clear  compacted board, held until the next pass completes
//   done_clear          one-cycle pulse, result valid
//   lines_cleared       full rows removed in the last completed pass
//   busy                high while a pass is scanning or shifting
module row_clear_engine #(
  parameter int         ROWS        = 20,
  parameter int         COLS        = 10,
  parameter logic [2:0] CLEAR_STATE = 3'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           game_current_state,
  input  logic [ROWS*COLS-1:0] blocks_exist,
  output logic [ROWS*COLS-1:0] blocks_exist_clear,
  output logic                 done_clear,
  output logic [4:0]           lines_cleared,
  output logic                 busy
);

  localparam int N  = ROWS * COLS;
  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]    state;
  logic [N-1:0]  board;
  logic [PW-1:0] ptr;
  logic [4:0]    cnt;
  logic          armed;

  logic          in_clear;
  logic          cur_full;
  logic          moved_full;
  logic [PW-1:0] above_row;
  logic [N-1:0]  shifted;

  function automatic logic row_full(input logic [N-1:0] b, input logic [PW-1:0] r);
    return &b[int'(r)*COLS +: COLS];
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  assign in_clear = (game_current_state == CLEAR_STATE);
  assign cur_full = row_full(board, ptr);

  // The row that a shift brings down to the pointer is checked in the SHIFT
  // cycle itself, using the pre-shift copy one row up. A run of full rows
  // therefore costs exactly one cycle per removed row. When the pointer is at
  // row 0, the incoming row is all zeros and can never be full.
  assign above_row  = (ptr == '0) ? '0 : ptr - 1'b1;
  assign moved_full = (ptr != '0) && row_full(board, above_row);

  always_comb begin
    shifted = board;
    shifted[0 +: COLS] = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (r <= int'(ptr))
        shifted[r*COLS +: COLS] = board[(r-1)*COLS +: COLS];
    end
  end

  assign busy = (state == S_SCAN) || (state == S_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      board              <= '0;
      ptr                <= '0;
      cnt                <= '0;
      armed              <= 1'b1;
      blocks_exist_clear <= '0;
      lines_cleared      <= '0;
      done_clear         <= 1'b0;
    end else begin
      done_clear <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_clear && armed) begin
            board <= blocks_exist;
            ptr   <= PW'(ROWS - 1);
            cnt   <= '0;
            armed <= 1'b0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!in_clear) begin
            armed <= 1'b1;
            state <= S_IDLE;
          end else if (cur_full) begin
            state <= S_SHIFT;
          end else if (ptr == '0) begin
            blocks_exist_clear <= board;
            lines_cleared      <= cnt;
            done_clear         <= 1'b1;
            state              <= S_DONE;
          end else begin
            ptr <= ptr - 1'b1;
          end
        end
        S_SHIFT: begin
          if (!in_clear) begin
            armed <= 1'b1;
            state <= S_IDLE;
          end else begin
            board <= shifted;
            cnt   <= sat_inc(cnt);
            if (moved_full) begin
              state <= S_SHIFT;
            end else if (ptr == '0) begin
              blocks_exist_clear <= shifted;
              lines_cleared      <= sat_inc(cnt);
              done_clear         <= 1'b1;
              state              <= S_DONE;
            end else begin
              ptr   <= ptr - 1'b1;
              state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!in_clear) begin
            armed <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_clear_engine.sv
module tb_row_clear_engine;

  localparam int         ROWS  = 20;
  localparam int         COLS  = 10;
  localparam int         N     = ROWS * COLS;
  localparam logic [2:0] CLEAR = 3'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   gs  = 3'd0;
  logic [N-1:0] blocks_exist = '0;
  logic [N-1:0] blocks_exist_clear;
  logic         done_clear;
  logic [4:0]   lines_cleared;
  logic         busy;

  int total  = 0;
  int passed = 0;

  row_clear_engine #(.ROWS(ROWS), .COLS(COLS), .CLEAR_STATE(CLEAR)) dut (
    .clk                (clk),
    .rst                (rst),
    .game_current_state (gs),
    .blocks_exist       (blocks_exist),
    .blocks_exist_clear (blocks_exist_clear),
    .done_clear         (done_clear),
    .lines_cleared      (lines_cleared),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] bin;
    logic [N-1:0] bexp;
    int           lines;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [N-1:0] rowmask(input int r);
    logic [N-1:0] m;
    m = '0;
    m[r*COLS +: COLS] = '1;
    return m;
  endfunction

  function automatic logic [N-1:0] bitm(input int i);
    logic [N-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_vec(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Starts a pass in the current cycle T, then scrambles blocks_exist at T+1.
  // Observes 60 cycles and checks latency, pulse count, busy and results.
  task automatic run_pass(input logic [N-1:0] bin, input logic [N-1:0] bexp,
                          input int exp_lines, input int exp_lat, input string name);
    int first;
    int pulses;
    int busy_cnt;
    logic [N-1:0] got_b;
    logic [4:0]   got_l;
    first = -1; pulses = 0; busy_cnt = 0;
    got_b = '0; got_l = '0;
    blocks_exist = bin;
    gs = CLEAR;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 1) blocks_exist = ~bin;
      if (done_clear) begin
        pulses++;
        if (first < 0) begin
          first = c;
          got_b = blocks_exist_clear;
          got_l = lines_cleared;
        end
      end
      if (busy) busy_cnt++;
    end
    check_int({name, " latency"}, first, exp_lat);
    check_int({name, " pulses"}, pulses, 1);
    check_int({name, " busy_cycles"}, busy_cnt, exp_lat - 1);
    check_vec({name, " board"}, got_b, bexp);
    check_int({name, " lines"}, int'(got_l), exp_lines);
  endtask

  task automatic idle_gap();
    gs = 3'd0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int busy7;
    logic [N-1:0] prev_b;
    logic [4:0]   prev_l;

    vecs[0] = '{'0, '0, 0, 21, "empty"};
    vecs[1] = '{rowmask(19) | bitm(180), bitm(190), 1, 22, "row19"};
    vecs[2] = '{rowmask(16) | rowmask(17) | rowmask(18) | rowmask(19) | bitm(150) | bitm(159),
                bitm(190) | bitm(199), 4, 25, "rows16_19"};
    vecs[3] = '{rowmask(19) | rowmask(17) | bitm(185) | bitm(162),
                bitm(195) | bitm(182), 2, 23, "rows19_17"};
    vecs[4] = '{'1, '0, 20, 41, "full"};
    vecs[5] = '{rowmask(0) | bitm(199), bitm(199), 1, 22, "top_row"};

    // Reset state
    #2;
    check_vec("rst board", blocks_exist_clear, '0);
    check_int("rst lines", int'(lines_cleared), 0);
    check_int("rst done", int'(done_clear), 0);
    check_int("rst busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_pass(vecs[i].bin, vecs[i].bexp, vecs[i].lines, vecs[i].lat, vecs[i].name);
      idle_gap();
    end

    // Full board, then dwell in CLEAR_STATE: exactly one pass
    run_pass('1, '0, 20, 41, "dwell");
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (done_clear) pulses++;
    end
    check_int("dwell extra_pulses", pulses, 0);
    check_int("dwell lines_held", int'(lines_cleared), 20);
    idle_gap();

    // Abort at T+5, re-enter at T+10
    prev_b = blocks_exist_clear;
    prev_l = lines_cleared;
    blocks_exist = '1;
    gs = CLEAR;
    pulses = 0;
    busy7 = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 5) gs = 3'd0;
      if (c == 7) busy7 = int'(busy);
      if (done_clear) pulses++;
    end
    check_int("abort pulses", pulses, 0);
    check_int("abort busy", busy7, 0);
    check_vec("abort board_held", blocks_exist_clear, prev_b);
    check_int("abort lines_held", int'(lines_cleared), int'(prev_l));
    run_pass('0, '0, 0, 21, "reenter");
    idle_gap();

    // Leave non-zero results, then reset mid-pass
    run_pass(vecs[1].bin, vecs[1].bexp, 1, 22, "pre_rst");
    idle_gap();
    blocks_exist = '1;
    gs = CLEAR;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_vec("midrst board", blocks_exist_clear, '0);
    check_int("midrst lines", int'(lines_cleared), 0);
    check_int("midrst done", int'(done_clear), 0);
    check_int("midrst busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_pass('1, '0, 20, 41, "post_rst");
    idle_gap();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
